pool_vmax_buffer: RTL and testbench

- Upstream feeder for the pooling engine. Accepts the raster feature-map AXIS stream: 32-bit words, each holding 4 signed int8 channels, channel-fastest, then column, then row.
- Buffers each even row. As the matching odd row streams in, it emits the bytewise signed max of the vertically paired words.
- The downstream pool compute therefore only performs the horizontal 2:1 reduction.
- Frame geometry (Flen, num_INCH) comes from the pool APB register block.

---
 rtl/pool_vmax_buffer.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_pool_vmax_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_vmax_buffer.sv
// -----------------------------------------------------------------------------
// pool_vmax_buffer
//
// Upstream feeder for the pooling engine. Takes the raster feature-map stream
// (32-bit words, four signed int8 channels per word, channel-fastest, then
// column, then row), stores every even row, and while the matching odd row
// streams in emits the bytewise signed maximum of the vertically paired words.
// The downstream pool compute only has to do the horizontal 2:1 reduction.
//
// Optional feature (compile-time macro POOL_VMAX_TLAST_CHECK_EN):
//   defined   - err is a sticky flag set when s_axis_tlast disagrees with the
//               real end of frame on any accepted word; cleared by start.
//   undefined - err is tied to 0 and s_axis_tlast is ignored.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   start            one-cycle pulse, latches flen/num_inch when idle
//   flen             feature-map width = height in pixels
//   num_inch         input channels, 1..256
//   done             one-cycle pulse at end of frame
//   busy             high from accepted start until done
//   err              sticky TLAST mismatch flag (see macro above)
//   s_axis_*         input stream (tready out; tdata/tvalid/tlast in)
//   m_axis_*         vertical-max output stream (tready in; tdata/tvalid/tlast out)
//   state_dbg        current FSM state encoding, for observation only
//
// Handshake: a word moves on a rising clk edge when tvalid && tready are both
// high. A source holds tvalid and keeps tdata/tlast stable until that edge;
// tvalid never waits for tready. m_axis follows the same rule as a source.
// -----------------------------------------------------------------------------
module pool_vmax_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [5:0]        flen,
    input  logic [8:0]        num_inch,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = 12;
    localparam int LANES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_MERGE = 3'd2,
        ST_TAIL  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wpr_q, wpr_d;
    logic [4:0]         pairs_q, pairs_d;
    logic               odd_q, odd_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [4:0]         pair_cnt_q, pair_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    // Row buffer: synchronous read, no reset (every even row is fully
    // rewritten before it is read back).
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  rd_data_q;
    logic [ADDR_W-1:0]  rd_addr;
    logic               buf_we;

    logic               s_ready;
    logic               s_hs;
    logic               idx_last;
    logic               pair_last;
    logic [6:0]         geo_wpp;
    logic [CNT_W-1:0]   geo_wpr;

    // Geometry computed from the live inputs; only latched on a valid start.
    assign geo_wpp = 7'((num_inch + 9'd3) >> 2);
    assign geo_wpr = CNT_W'({6'd0, flen} * {5'd0, geo_wpp});

    assign idx_last  = (idx_q == (wpr_q - 12'd1));
    assign pair_last = (({1'b0, pair_cnt_q} + 6'd1) == {1'b0, pairs_q});

    function automatic logic [DATA_W-1:0] vmax(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[8*i +: 8] = ($signed(a[8*i +: 8]) > $signed(b[8*i +: 8])) ?
                          a[8*i +: 8] : b[8*i +: 8];
        end
        return r;
    endfunction

    // Input ready per state. In MERGE the one-entry output register must be
    // empty or emptying this cycle.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_FILL, ST_TAIL: s_ready = 1'b1;
            ST_MERGE:         s_ready = !out_valid_q || m_axis_tready;
            default:          s_ready = 1'b0;
        endcase
    end

    assign s_hs   = s_axis_tvalid && s_ready;
    assign buf_we = (state_q == ST_FILL) && s_hs;

    always_comb begin
        state_d     = state_q;
        wpr_d       = wpr_q;
        pairs_d     = pairs_q;
        odd_d       = odd_q;
        idx_d       = idx_q;
        pair_cnt_d  = pair_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        rd_addr     = '0;

        // Output register drains whenever downstream takes it, in any state;
        // a MERGE load below overrides this in the same cycle.
        if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((flen == 6'd0) || (num_inch == 9'd0)) begin
                        done_d = 1'b1;
                    end else begin
                        wpr_d      = geo_wpr;
                        pairs_d    = flen[5:1];
                        odd_d      = flen[0];
                        idx_d      = '0;
                        pair_cnt_d = '0;
                        busy_d     = 1'b1;
                        // A single row has no partner: consume it as the tail.
                        state_d    = (flen[5:1] == 5'd0) ? ST_TAIL : ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                // Keep address 0 prefetched so the first MERGE word finds its
                // partner already on rd_data_q.
                rd_addr = '0;
                if (s_hs) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = ST_MERGE;
                    end else begin
                        idx_d = idx_q + 12'd1;
                    end
                end
            end

            ST_MERGE: begin
                if (s_hs) begin
                    out_valid_d = 1'b1;
                    out_data_d  = vmax(s_axis_tdata, rd_data_q);
                    out_last_d  = idx_last && pair_last;
                    if (idx_last) begin
                        idx_d      = '0;
                        pair_cnt_d = pair_cnt_q + 5'd1;
                        rd_addr    = '0;
                        if (pair_last) begin
                            state_d = odd_q ? ST_TAIL : ST_DRAIN;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        idx_d   = idx_q + 12'd1;
                        // Fetch the partner of the next word now.
                        rd_addr = idx_q[ADDR_W-1:0] + ADDR_ONE;
                    end
                end else begin
                    // Hold the current partner on the read port while stalled.
                    rd_addr = idx_q[ADDR_W-1:0];
                end
            end

            ST_TAIL: begin
                if (s_hs) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + 12'd1;
                    end
                end
            end

            ST_DRAIN: begin
                if (!out_valid_q || m_axis_tready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            wpr_q       <= '0;
            pairs_q     <= '0;
            odd_q       <= 1'b0;
            idx_q       <= '0;
            pair_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wpr_q       <= wpr_d;
            pairs_q     <= pairs_d;
            odd_q       <= odd_d;
            idx_q       <= idx_d;
            pair_cnt_q  <= pair_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            mem_q[idx_q[ADDR_W-1:0]] <= s_axis_tdata;
        end
        rd_data_q <= mem_q[rd_addr];
    end

`ifdef POOL_VMAX_TLAST_CHECK_EN
    logic err_q, err_d;
    logic word_is_frame_last;

    // The final accepted word is either the tail row's last word or, for even
    // flen, the last word of the final pair.
    assign word_is_frame_last = idx_last &&
                                (((state_q == ST_MERGE) && pair_last && !odd_q) ||
                                 (state_q == ST_TAIL));

    always_comb begin
        err_d = err_q;
        if ((state_q == ST_IDLE) && start) begin
            err_d = 1'b0;
        end else if (s_hs && (s_axis_tlast != word_is_frame_last)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign err = 1'b0;
`endif

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_pool_vmax_buffer.sv
// -----------------------------------------------------------------------------
// tb_pool_vmax_buffer
//
// Self-checking bench for pool_vmax_buffer: a table of hand-computed
// vertical-max word triples, a table of frame geometries with random-data
// frames checked against a small bytewise reference, and hand-written
// sequences for zero geometry, start while busy, reset mid-frame and the
// optional TLAST check.
// -----------------------------------------------------------------------------
module tb_pool_vmax_buffer;

    typedef struct packed {
        logic [31:0] even_w;
        logic [31:0] odd_w;
        logic [31:0] exp_w;
    } vmax_vec_t;

    typedef struct {
        int flen;
        int ninch;
        int v_pct;
        int r_pct;
        bit chk_lat;
    } frame_vec_t;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [5:0]  flen;
    logic [8:0]  num_inch;
    logic        done;
    logic        busy;
    logic        err;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] in_q[$];
    logic        in_last_q[$];
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];

    vmax_vec_t  vtab[10];
    frame_vec_t ftab[3];

    pool_vmax_buffer dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .flen          (flen),
        .num_inch      (num_inch),
        .done          (done),
        .busy          (busy),
        .err           (err),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_vmax(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        byte sa;
        byte sb;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            sa = a[8*i +: 8];
            sb = b[8*i +: 8];
            r[8*i +: 8] = (sa >= sb) ? sa : sb;
        end
        return r;
    endfunction

    // ---------------- frame builders ----------------
    // flen = 2 frame from table rows [first, first+cnt): even row then odd row.
    task automatic build_table_frame(input int first, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            in_q.push_back(vtab[first+k].even_w);
            in_last_q.push_back(1'b0);
        end
        for (int k = 0; k < cnt; k++) begin
            in_q.push_back(vtab[first+k].odd_w);
            in_last_q.push_back(k == cnt - 1);
            exp_q.push_back(vtab[first+k].exp_w);
            exp_last_q.push_back(k == cnt - 1);
        end
    endtask

    task automatic build_rand_frame(input int f, input int n);
        int wpr;
        int pairs;
        logic [31:0] even_row[256];
        logic [31:0] w;
        wpr   = f * ((n + 3) / 4);
        pairs = f / 2;
        for (int r = 0; r < f; r++) begin
            for (int k = 0; k < wpr; k++) begin
                w = $urandom;
                in_q.push_back(w);
                in_last_q.push_back((r == f - 1) && (k == wpr - 1));
                if ((r % 2) == 0) begin
                    even_row[k] = w;
                end else begin
                    exp_q.push_back(ref_vmax(even_row[k], w));
                    exp_last_q.push_back((r == 2 * pairs - 1) && (k == wpr - 1));
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic start_frame(input logic [5:0] f, input logic [8:0] n);
        @(posedge clk); #1;
        start    = 1'b1;
        flen     = f;
        num_inch = n;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Streams in_q into the DUT and checks every output word against exp_q.
    // bs_cyc >= 0 pulses start (with other geometry) at that cycle of the run.
    task automatic run_frame(input int v_pct, input int r_pct, input int bs_cyc,
                             input bit chk_lat, input string tag);
        int it;
        int last_out_it;
        int done_it;
        bit stall_prev;
        bit in_hs;
        logic [31:0] data_prev;
        logic        last_prev;
        logic [31:0] ew;
        logic        el;
        it = 0; last_out_it = -1; done_it = -1; stall_prev = 1'b0;
        data_prev = '0; last_prev = 1'b0;
        while ((done_it < 0) && (it < 2000)) begin
            @(negedge clk);
            if (it == 0) check($sformatf("%s_busy", tag), busy, 1'b1);
            if (stall_prev) begin
                check($sformatf("%s_hold", tag), {m_tvalid, m_tlast, m_tdata},
                      {1'b1, last_prev, data_prev});
            end
            stall_prev = m_tvalid && !m_tready;
            data_prev  = m_tdata;
            last_prev  = m_tlast;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s_extra_out", tag), {m_tlast, m_tdata}, 33'h0_dead_beef);
                end else begin
                    ew = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    check($sformatf("%s_out", tag), {m_tlast, m_tdata}, {el, ew});
                end
                last_out_it = it;
            end
            in_hs = s_tvalid && s_tready;
            if (done) begin
                done_it = it;
                check($sformatf("%s_end_flags", tag), {busy, err}, 2'b00);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (in_hs) begin
                void'(in_q.pop_front());
                void'(in_last_q.pop_front());
                s_tvalid = 1'b0;
            end
            if (it == bs_cyc) begin
                start    = 1'b1;
                flen     = 6'd5;
                num_inch = 9'd1;
            end
            if (!s_tvalid && (in_q.size() > 0) && ($urandom_range(0, 99) < v_pct)) begin
                s_tvalid = 1'b1;
                s_tdata  = in_q[0];
                s_tlast  = in_last_q[0];
            end
            m_tready = ($urandom_range(0, 99) < r_pct);
            it++;
        end
        check($sformatf("%s_done_seen", tag), (done_it >= 0), 1'b1);
        check($sformatf("%s_in_left", tag), in_q.size(), 0);
        check($sformatf("%s_out_left", tag), exp_q.size(), 0);
        if (chk_lat) check($sformatf("%s_done_lat", tag), done_it - last_out_it, 1);
        in_q.delete(); in_last_q.delete(); exp_q.delete(); exp_last_q.delete();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        check($sformatf("%s_done_pulse", tag), done, 1'b0);
    endtask

    // Degenerate geometry: done the cycle after start, no busy, no ready.
    task automatic zero_frame(input logic [5:0] f, input logic [8:0] n, input string tag);
        @(posedge clk); #1;
        start = 1'b1; flen = f; num_inch = n;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check($sformatf("%s_p1", tag), {done, busy, s_tready}, 3'b100);
        @(negedge clk);
        check($sformatf("%s_p2", tag), {done, busy, s_tready}, 3'b000);
    endtask

    // ---------------- test ----------------
    initial begin
        vtab[0] = '{32'h01FF7F80, 32'h02FE7E81, 32'h02FF7F81};
        vtab[1] = '{32'h10101010, 32'h0F111011, 32'h10111011};
        vtab[2] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        vtab[3] = '{32'h80808080, 32'h7F7F7F7F, 32'h7F7F7F7F};
        vtab[4] = '{32'h807F01FE, 32'h7F80FE01, 32'h7F7F0101};
        vtab[5] = '{32'h12345678, 32'h87654321, 32'h12655678};
        vtab[6] = '{32'hC0C0C0C0, 32'hB0D0A0E0, 32'hC0D0C0E0};
        vtab[7] = '{32'h01020304, 32'h01020304, 32'h01020304};
        vtab[8] = '{32'hFF00FF00, 32'h00FF00FF, 32'h00000000};
        vtab[9] = '{32'hDEADBEEF, 32'h7FFFFF80, 32'h7FFFFFEF};

        ftab[0] = '{4, 8, 50, 50, 1'b1};
        ftab[1] = '{3, 4, 100, 100, 1'b0};
        ftab[2] = '{1, 4, 70, 60, 1'b0};

        rstn = 1'b0; start = 1'b0; flen = '0; num_inch = '0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {done, busy, err, s_tready, m_tvalid, m_tlast, m_tdata, state_dbg}, '0);
        rstn = 1'b1;
        m_tready = 1'b1;

        // Basic flen=2, num_inch=4 frame with continuous ready.
        build_table_frame(0, 2);
        start_frame(6'd2, 9'd4);
        run_frame(100, 100, -1, 1'b1, "basic");

        // flen=2, num_inch=16: eight hand-computed lane patterns, with stalls.
        build_table_frame(2, 8);
        start_frame(6'd2, 9'd16);
        run_frame(70, 60, -1, 1'b1, "table");

        // Geometry table with random data: 4x4x8 at 50% stalls, odd flen, flen=1.
        for (int i = 0; i < 3; i++) begin
            build_rand_frame(ftab[i].flen, ftab[i].ninch);
            start_frame(6'(ftab[i].flen), 9'(ftab[i].ninch));
            run_frame(ftab[i].v_pct, ftab[i].r_pct, -1, ftab[i].chk_lat,
                      $sformatf("geo%0d", i));
        end

        zero_frame(6'd0, 9'd4, "zero_flen");
        zero_frame(6'd5, 9'd0, "zero_inch");

        // start pulsed during the frame must not disturb it.
        build_table_frame(0, 2);
        start_frame(6'd2, 9'd4);
        run_frame(50, 100, 1, 1'b1, "busy_start");

        // Reset while a MERGE output is stalled.
        start_frame(6'd2, 9'd4);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = 32'h11111111;
        @(posedge clk); #1;
        s_tdata  = 32'h22222222;
        @(posedge clk); #1;
        s_tdata  = 32'h33333333;
        @(posedge clk); #1;
        s_tdata  = 32'h44444444;
        check("pre_reset_state", state_dbg, 3'd2);
        check("pre_reset_out", {m_tvalid, m_tdata}, {1'b1, 32'h33333333});
        #2;
        rstn = 1'b0;
        #1;
        check("mid_reset_outs",
              {m_tvalid, m_tlast, m_tdata, s_tready, busy, done, err, state_dbg}, '0);
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        m_tready = 1'b1;
        build_table_frame(0, 2);
        start_frame(6'd2, 9'd4);
        run_frame(100, 100, -1, 1'b1, "post_reset");

`ifdef POOL_VMAX_TLAST_CHECK_EN
        begin
            logic [31:0] tw[4];
            logic        tl[4];
            tw[0] = vtab[0].even_w; tw[1] = vtab[1].even_w;
            tw[2] = vtab[0].odd_w;  tw[3] = vtab[1].odd_w;
            tl[0] = 1'b0; tl[1] = 1'b1; tl[2] = 1'b0; tl[3] = 1'b1;
            start_frame(6'd2, 9'd4);
            m_tready = 1'b1;
            s_tvalid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                s_tdata = tw[k];
                s_tlast = tl[k];
                @(posedge clk); #1;
                if (k == 0) check("tl_err_before", err, 1'b0);
                if (k == 1) check("tl_err_rise", err, 1'b1);
            end
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done) break;
            end
            check("tl_done", done, 1'b1);
            check("tl_err_hold", err, 1'b1);
            start_frame(6'd0, 9'd4);
            check("tl_err_clear", err, 1'b0);
            @(negedge clk);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
